// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADD  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full-adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: WIDTH cycles per add through one full_adder cell.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_out
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_nxt;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt;
    logic               fa_s;
    logic               fa_c;
    logic               last_bit;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at index 0.
    always_comb begin
        sum_nxt            = sum_q >> 1;
        sum_nxt[WIDTH-1]   = fa_s;
    end

    assign last_bit = (state == ST_ADD) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a_in;
                        b_sh    <= b_in;
                        carry_q <= cin_in;
                        cnt     <= '0;
                        state   <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum_q   <= sum_nxt;
                    carry_q <= fa_c;
                    cnt     <= cnt + CNT_W'(1);
                    if (last_bit)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign sum_out   = sum_q;
    assign cout_out  = carry_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // On the MSB cycle carry_q is the carry into the MSB and fa_c the carry out.
    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (last_bit)
            ovf_q <= carry_q ^ fa_c;
    end

    assign ovf_out = ovf_q;
`endif

endmodule
